// File: rtl/semafor_pkg.sv
// Shared state codes, BCD helper and 7-segment patterns for the traffic-light display.
package semafor_pkg;

  typedef enum logic [2:0] {
    ST_ROSU        = 3'b000,
    ST_VERDE       = 3'b001,
    ST_GALBEN      = 3'b010,
    ST_INTERMITENT = 3'b111
  } stare_t;

  typedef struct packed {
    logic [3:0] zeci;
    logic [3:0] unit;
  } bcd_t;

  typedef struct packed {
    logic rosu;
    logic galben;
    logic verde;
    logic err;
    logic gol;
  } lampi_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic bcd_t to_bcd(input int v);
    bcd_t r;
    r.zeci = 4'(v / 10);
    r.unit = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-low 7-segment pattern; codes above 9 render blank.
module bcd_to_7seg
  import semafor_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: ;
    endcase
  end

endmodule

// File: rtl/afisaj_semafor.sv
// Traffic-light state decoder with per-state BCD countdown on a 2-digit muxed display.
// Optional macro BLINK_VERDE_EN: green lamp blinks during the last 3 seconds of green.
module afisaj_semafor
  import semafor_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int MUX_DIV     = 50_000,
  parameter int T_ROSU      = 30,
  parameter int T_VERDE     = 25,
  parameter int T_GALBEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] stare_semafor,
  output logic       lumina_rosu,
  output logic       lumina_galben,
  output logic       lumina_verde,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_PER_SEC - 1);
  localparam logic [MW-1:0] MUX_TC   = MW'(MUX_DIV - 1);
  localparam bcd_t BCD_ROSU   = to_bcd(T_ROSU);
  localparam bcd_t BCD_VERDE  = to_bcd(T_VERDE);
  localparam bcd_t BCD_GALBEN = to_bcd(T_GALBEN);

  logic [2:0]    stare_q;
  logic          chg, tick;
  logic [PW-1:0] presc;
  bcd_t          cnt_q, cnt_load;
  logic          blink;
  logic [MW-1:0] mux_cnt;
  logic          sel_zeci;
  logic [3:0]    cifra;
  logic [6:0]    seg_cifra;
  logic          verde_on;
  lampi_t        lampi_d;

  assign chg  = (stare_semafor != stare_q);
  // A state change restarts the second, so it always beats a coincident tick.
  assign tick = (presc == PRESC_TC) && !chg;

  always_comb begin
    cnt_load = '0;
    case (stare_semafor)
      ST_ROSU:   cnt_load = BCD_ROSU;
      ST_VERDE:  cnt_load = BCD_VERDE;
      ST_GALBEN: cnt_load = BCD_GALBEN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stare_q <= ST_ROSU;
      presc   <= '0;
      cnt_q   <= BCD_ROSU;
      blink   <= 1'b0;
    end else begin
      stare_q <= stare_semafor;
      if (chg) begin
        presc <= '0;
        cnt_q <= cnt_load;
        blink <= 1'b0;
      end else begin
        presc <= (presc == PRESC_TC) ? '0 : presc + PW'(1);
        if (tick) begin
          blink <= ~blink;
          if (cnt_q != '0) begin
            if (cnt_q.unit == 4'd0) begin
              cnt_q.unit <= 4'd9;
              cnt_q.zeci <= cnt_q.zeci - 4'd1;
            end else begin
              cnt_q.unit <= cnt_q.unit - 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef BLINK_VERDE_EN
  assign verde_on = (cnt_q.zeci == 4'd0 && cnt_q.unit <= 4'd3) ? blink : 1'b1;
`else
  assign verde_on = 1'b1;
`endif

  always_comb begin
    lampi_d = '0;
    case (stare_q)
      ST_ROSU:   lampi_d.rosu   = 1'b1;
      ST_VERDE:  lampi_d.verde  = verde_on;
      ST_GALBEN: lampi_d.galben = 1'b1;
      ST_INTERMITENT: begin
        lampi_d.galben = blink;
        lampi_d.gol    = 1'b1;
      end
      default: begin
        lampi_d.galben = blink;
        lampi_d.gol    = 1'b1;
        lampi_d.err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lumina_rosu   <= 1'b0;
      lumina_galben <= 1'b0;
      lumina_verde  <= 1'b0;
      err           <= 1'b0;
    end else begin
      lumina_rosu   <= lampi_d.rosu;
      lumina_galben <= lampi_d.galben;
      lumina_verde  <= lampi_d.verde;
      err           <= lampi_d.err;
    end
  end

  assign cifra = sel_zeci ? cnt_q.zeci : cnt_q.unit;

  bcd_to_7seg u_bcd (
    .bcd (cifra),
    .seg (seg_cifra)
  );

  // The mux keeps cycling in blank modes so the anode duty stays uniform.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt  <= '0;
      sel_zeci <= 1'b0;
      seg      <= SEG_BLANK;
      an       <= 2'b11;
    end else begin
      if (mux_cnt == MUX_TC) begin
        mux_cnt  <= '0;
        sel_zeci <= ~sel_zeci;
      end else begin
        mux_cnt <= mux_cnt + MW'(1);
      end
      an  <= sel_zeci ? 2'b01 : 2'b10;
      seg <= (lampi_d.gol || (sel_zeci && cnt_q.zeci == 4'd0)) ? SEG_BLANK : seg_cifra;
    end
  end

endmodule

// File: tb/tb_afisaj_semafor.sv
// Directed bench: reset, countdown, change-vs-tick, flashing, invalid code, two-digit display.
module tb_afisaj_semafor;

  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30;
  localparam logic [6:0] P4 = 7'h19, P5 = 7'h12, P9 = 7'h10, BL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] stare;
  logic       rosu, galben, verde, err;
  logic [6:0] seg;
  logic [1:0] an;
  logic       rosu2, galben2, verde2, err2;
  logic [6:0] seg2;
  logic [1:0] an2;

  int cyc = 0;
  int base;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  afisaj_semafor #(.CLK_PER_SEC(10), .MUX_DIV(2), .T_ROSU(5), .T_VERDE(4), .T_GALBEN(2)) dut (
    .clk(clk), .rst(rst), .stare_semafor(stare),
    .lumina_rosu(rosu), .lumina_galben(galben), .lumina_verde(verde),
    .seg(seg), .an(an), .err(err)
  );

  afisaj_semafor #(.CLK_PER_SEC(10), .MUX_DIV(2), .T_ROSU(12), .T_VERDE(4), .T_GALBEN(2)) dut2 (
    .clk(clk), .rst(rst), .stare_semafor(stare),
    .lumina_rosu(rosu2), .lumina_galben(galben2), .lumina_verde(verde2),
    .seg(seg2), .an(an2), .err(err2)
  );

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic [2:0] code);
    rst   = 1'b1;
    stare = code;
    repeat (n) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with green on the bus
    rst   = 1'b1;
    stare = 3'b001;
    base  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_rosu", rosu, 1'b0);
      chk1("rst_galben", galben, 1'b0);
      chk1("rst_verde", verde, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk7("rst_seg", seg, BL);
      chk2("rst_an", an, 2'b11);
    end
    rst  = 1'b0;
    base = cyc;
    goto(2);  chk1("t1_verde", verde, 1'b1); chk1("t1_rosu", rosu, 1'b0);
    goto(5);  chk2("t1_an", an, 2'b10); chk7("t1_ones04", seg, P4);

    // Countdown in red: 05..00, then saturate
    do_reset(1, 3'b000);
    chk1("rst2_rosu", rosu2, 1'b0);
    chk1("rst2_galben", galben2, 1'b0);
    chk1("rst2_verde", verde2, 1'b0);
    chk1("rst2_err", err2, 1'b0);
    chk7("rst2_seg", seg2, BL);
    chk2("rst2_an", an2, 2'b11);
    goto(5);  chk7("t2_05", seg, P5); chk1("t2_rosu", rosu, 1'b1);
    goto(7);  chk2("t2_an_tens", an, 2'b01); chk7("t2_tens_blank", seg, BL);
    goto(13); chk7("t2_04", seg, P4);
    goto(25); chk7("t2_03", seg, P3);
    goto(33); chk7("t2_02", seg, P2);
    goto(45); chk7("t2_01", seg, P1);
    goto(53); chk7("t2_00", seg, P0);
    goto(55); chk7("t2_tens_blank2", seg, BL);
    goto(73); chk7("t2_hold_a", seg, P0);
    goto(81); chk7("t2_hold_b", seg, P0);
    goto(89); chk7("t2_hold_c", seg, P0); chk1("t2_rosu_end", rosu, 1'b1);

    // Change to yellow while prescaler sits at terminal count
    stare = 3'b010;
    goto(91);  chk1("t3_galben", galben, 1'b1); chk1("t3_rosu", rosu, 1'b0);
    goto(97);  chk7("t3_load02", seg, P2);
    goto(101); chk7("t3_01", seg, P1);
    goto(109); chk7("t3_01b", seg, P1);
    goto(113); chk7("t3_00", seg, P0);

    // Flashing yellow
    goto(119); stare = 3'b111;
    goto(125); chk7("t4_seg_ones", seg, BL); chk2("t4_an_ones", an, 2'b10);
    goto(127); chk7("t4_seg_tens", seg, BL); chk2("t4_an_tens", an, 2'b01);
    goto(130); chk1("t4_y130", galben, 1'b0);
    goto(131); chk1("t4_y131", galben, 1'b1);
    chk1("t4_rosu", rosu, 1'b0); chk1("t4_verde", verde, 1'b0); chk1("t4_err", err, 1'b0);
    goto(140); chk1("t4_y140", galben, 1'b1);
    goto(141); chk1("t4_y141", galben, 1'b0);
    goto(150); chk1("t4_y150", galben, 1'b0);
    goto(151); chk1("t4_y151", galben, 1'b1);

    // Invalid code, then back to green
    goto(159); stare = 3'b101;
    goto(160); chk1("t5_err_pre", err, 1'b0);
    goto(161); chk1("t5_err", err, 1'b1);
    goto(165); chk1("t5_y165", galben, 1'b0); chk7("t5_seg_ones", seg, BL);
    chk1("t5_rosu", rosu, 1'b0); chk1("t5_verde", verde, 1'b0);
    goto(167); chk7("t5_seg_tens", seg, BL);
    goto(170); chk1("t5_y170", galben, 1'b0);
    goto(171); chk1("t5_y171", galben, 1'b1);
    goto(179); stare = 3'b001;
    goto(180); chk1("t5_err_hold", err, 1'b1);
    goto(181); chk1("t5_err_clr", err, 1'b0); chk1("t5_verde", verde, 1'b1);
    chk1("t5_galben_off", galben, 1'b0);
    goto(185); chk2("t5_an", an, 2'b10); chk7("t5_reload04", seg, P4);
    goto(187); chk7("t5_tens_blank", seg, BL);
    goto(191); chk1("t5_verde191", verde, 1'b1);
`ifdef BLINK_VERDE_EN
    goto(201); chk1("t5_verde_blink", verde, 1'b0);
`else
    goto(201); chk1("t5_verde_const", verde, 1'b1);
`endif

    // Two-digit countdown 12..09 on the second instance, then mid-count reset
    do_reset(1, 3'b000);
    goto(5);  chk2("t6_an5", an2, 2'b10); chk7("t6_ones2", seg2, P2);
    goto(7);  chk2("t6_an7", an2, 2'b01); chk7("t6_tens1", seg2, P1);
    goto(8);  chk2("t6_an8", an2, 2'b01);
    goto(9);  chk2("t6_an9", an2, 2'b10);
    goto(17); chk7("t6_11_ones", seg2, P1);
    goto(21); chk7("t6_10_ones", seg2, P0);
    goto(23); chk7("t6_10_tens", seg2, P1);
    goto(33); chk7("t6_09_ones", seg2, P9);
    goto(35); chk2("t6_an35", an2, 2'b01); chk7("t6_09_tens_blank", seg2, BL);
    chk1("t6_rosu", rosu2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("t6_rst_rosu", rosu2, 1'b0);
    chk1("t6_rst_galben", galben2, 1'b0);
    chk1("t6_rst_verde", verde2, 1'b0);
    chk1("t6_rst_err", err2, 1'b0);
    chk7("t6_rst_seg", seg2, BL);
    chk2("t6_rst_an", an2, 2'b11);
    rst  = 1'b0;
    base = cyc;
    goto(5);  chk7("t6_re_ones2", seg2, P2);
    goto(7);  chk7("t6_re_tens1", seg2, P1);
    goto(9);  chk7("t6_re_still12", seg2, P2);
    goto(13); chk7("t6_re_11", seg2, P1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
